// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared types for the multiply/divide unit
// Purpose: function codes accepted by the unit, FSM state encoding and an
//          operation-class helper.
// Ports:   none (package).
package mult_div_unit_pkg;

   typedef enum logic [5:0] {
      FUNCT_MTHI  = 6'h11,
      FUNCT_MTLO  = 6'h13,
      FUNCT_MULT  = 6'h18,
      FUNCT_MULTU = 6'h19,
      FUNCT_DIV   = 6'h1A,
      FUNCT_DIVU  = 6'h1B
   } funct_t;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      FIXUP
   } mdu_state_t;

   function automatic logic is_signed_op(funct_t f);
      return (f == FUNCT_MULT) || (f == FUNCT_DIV);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between CPU and multiply/divide unit
// Purpose: groups the start/fncode/operand request and the busy/done/hi/lo
//          results of the unit.
// Ports:   master - CPU side (drives start, fncode, a, b; reads busy, done, hi, lo)
//          slave  - unit side (the reverse)
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   import mult_div_unit_pkg::*;

   logic             start;
   funct_t           fncode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, fncode, a, b,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, fncode, a, b,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
// Purpose: executes MULT, MULTU, DIV, DIVU (WIDTH iterations plus a sign
//          fixup cycle) and MTHI/MTLO (single cycle).
// Ports:   clk     - clock, rising edge
//          reset_n - asynchronous active-low reset
//          bus     - slave side of mult_div_unit_if (start, fncode, a, b,
//                    busy, done, hi, lo)
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset_n,
   mult_div_unit_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   mdu_state_t         state_q, state_d;
   logic [CW-1:0]      cnt_q;
   // Multiply: {partial product, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend bits / quotient bits}.
   logic [2*WIDTH-1:0] work_q;
   logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor magnitude
   logic               neg_a_q, neg_b_q, div0_q, is_div_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               done_q;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign a_neg = is_signed_op(bus.fncode) & bus.a[WIDTH-1];
   assign b_neg = is_signed_op(bus.fncode) & bus.b[WIDTH-1];
   assign a_mag = a_neg ? -bus.a : bus.a;
   assign b_mag = b_neg ? -bus.b : bus.b;

   // Shift-add step; the carry out of the add becomes the new top bit.
   assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
   assign mul_next = work_q[0] ? {mul_sum, work_q[WIDTH-1:1]}
                               : {1'b0, work_q[2*WIDTH-1:1]};

   // Restoring step: trial-subtract the divisor from the shifted remainder;
   // bit WIDTH of the trial is the borrow.
   assign trial    = work_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
   assign div_next = trial[WIDTH] ? {work_q[2*WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

   // With a zero divisor the remainder half ends up holding |a|, so the
   // dividend-sign fixup below already restores a unchanged into hi.
   assign prod_fix = (neg_a_q ^ neg_b_q) ? -work_q : work_q;
   assign quot_fix = div0_q ? '1
                   : ((neg_a_q ^ neg_b_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0]);
   assign rem_fix  = neg_a_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               case (bus.fncode)
                  FUNCT_MULT, FUNCT_MULTU: state_d = MUL;
                  FUNCT_DIV,  FUNCT_DIVU:  state_d = DIV;
                  default:                 state_d = IDLE;
               endcase
            end
         end
         MUL, DIV: if (cnt_q == CW'(1)) state_d = FIXUP;
         FIXUP:    state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         work_q   <= '0;
         opnd_q   <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         div0_q   <= 1'b0;
         is_div_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  case (bus.fncode)
                     FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
                        is_div_q <= (bus.fncode == FUNCT_DIV) || (bus.fncode == FUNCT_DIVU);
                        if ((bus.fncode == FUNCT_DIV) || (bus.fncode == FUNCT_DIVU)) begin
                           work_q <= {{WIDTH{1'b0}}, a_mag};
                           opnd_q <= b_mag;
                        end else begin
                           work_q <= {{WIDTH{1'b0}}, b_mag};
                           opnd_q <= a_mag;
                        end
                        neg_a_q <= a_neg;
                        neg_b_q <= b_neg;
                        div0_q  <= (bus.b == '0);
                        cnt_q   <= CW'(WIDTH);
                     end
                     FUNCT_MTHI: hi_q <= bus.a;
                     FUNCT_MTLO: lo_q <= bus.a;
                     default: ;
                  endcase
               end
            end
            MUL: begin
               work_q <= mul_next;
               cnt_q  <= cnt_q - CW'(1);
            end
            DIV: begin
               work_q <= div_next;
               cnt_q  <= cnt_q - CW'(1);
            end
            FIXUP: begin
               if (is_div_q) begin
                  hi_q <= rem_fix;
                  lo_q <= quot_fix;
               end else begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It sits beside the combinational ALU in the execute stage and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply and divide run as radix-2 iterative datapaths behind a start/busy/done handshake. The CPU stalls on `busy` and reads `hi`/`lo` directly for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `fncode`  in  funct_t  operation select; sampled with `start`.
- `a`  in  WIDTH  rs operand; dividend/multiplicand; source value for MTHI/MTLO.
- `b`  in  WIDTH  rt operand; divisor/multiplier.
- `busy`  out  1  high while an iterative operation is in flight.
- `done`  out  1  one-cycle pulse when a MULT/DIV result lands in `hi`/`lo`.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, MUL, DIV, FIXUP.
- IDLE, `start`=1:
  - MULT/MULTU: load operands, go to MUL. Signed variants latch operand signs and work on magnitudes.
  - DIV/DIVU: same operand handling, go to DIV.
  - MTHI: `hi` <= `a`; stay in IDLE.
  - MTLO: `lo` <= `a`; stay in IDLE.
  - Any other `fncode`: ignored.
- MUL: shift-add, one multiplier bit per cycle, `WIDTH` cycles, into a 2×WIDTH working product. Then go to FIXUP.
- DIV: restoring division, one quotient bit per cycle, `WIDTH` cycles. Working remainder is WIDTH+1 bits to hold the trial subtract. Then go to FIXUP.
- FIXUP (one cycle):
  - Product: negate the 2×WIDTH product if operand signs differ (signed op only).
  - Quotient: negated if signs differ; remainder takes the dividend's sign.
  - Commit on the exit edge: `hi` <= upper/remainder, `lo` <= lower/quotient. Return to IDLE.
- Divide by zero (`b`=0, DIV or DIVU): `lo` = all ones, `hi` = `a` unmodified. The iterations still run; FIXUP forces these values.
- Signed overflow, most-negative ÷ −1: `lo` = 0x80000000, `hi` = 0. This falls out of magnitude arithmetic.
- Working registers are separate from `hi`/`lo`: `hi`/`lo` hold their previous values for the whole operation.
- Iteration counter: $clog2(WIDTH)+1 bits, counts down to zero.

## Timing
- Reset (asynchronous, immediate): state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, counter 0. Reset mid-operation discards all work.
- Edge E0 accepts `start`.
- `busy` = 1 from E0 through the FIXUP cycle, i.e. WIDTH+1 cycles.
- `hi`/`lo` update on edge E0+WIDTH+1.
- `done` = 1 for exactly the following cycle (first IDLE cycle). `busy` = 0 in that cycle.
- A new `start` is accepted in the same cycle that `done` is high.
- `start` while `busy`: ignored, including MTHI/MTLO.
- MTHI/MTLO: one-cycle latency. Result visible the cycle after the accepting edge; no `busy`, no `done`.
- `reset_n` low coincident with `start`: reset wins.

## Structure
- Shared package additions:
  - `funct_t` entries FUNCT_MULT 6'h18, FUNCT_MULTU 6'h19, FUNCT_DIV 6'h1A, FUNCT_DIVU 6'h1B, FUNCT_MTHI 6'h11, FUNCT_MTLO 6'h13.
  - `mdu_state_t` enum (IDLE, MUL, DIV, FIXUP).
- Single module. Both iterative datapaths share the 2×WIDTH working register and the counter; no sub-module.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi` 0xFFFFFFFE, `lo` 0x00000001. `busy` high for 33 cycles; `done` pulses exactly once.
- MULT −3 × 5 -> `hi` 0xFFFFFFFF, `lo` 0xFFFFFFF1.
- MULT 0x80000000 × 0x80000000 -> `hi` 0x40000000, `lo` 0.
- DIV −7 ÷ 2 -> `lo` 0xFFFFFFFD, `hi` 0xFFFFFFFF.
- DIVU 7 ÷ 2 -> `lo` 3, `hi` 1.
- Boundary divides:
  - DIVU 5 ÷ 0 -> `lo` 0xFFFFFFFF, `hi` 5.
  - DIV 0x80000000 ÷ 0xFFFFFFFF -> `lo` 0x80000000, `hi` 0.
- Handshake:
  - MTHI 0x1234 in IDLE -> `hi` 0x1234 next cycle, `lo` unchanged, `busy` stays 0.
  - MTLO or a second MULT issued during `busy` -> ignored. `hi`/`lo` keep old values until the commit edge.
  - Back-to-back `start` on the `done` cycle is accepted.
- `reset_n` pulsed low at iteration 10 of DIVU -> `busy`/`hi`/`lo` go to 0 immediately, no `done`. A following MULTU 6 × 7 gives `lo` 42, `hi` 0.
